// File: rtl/dff_bank_pkg.sv
// Shared encodings for the flip-flop bank sequencer: command opcodes and FSM states.
package dff_bank_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_EXEC  = 2'd1;
  localparam state_t ST_PULSE = 2'd2;
  localparam state_t ST_CHECK = 2'd3;

endpackage

// File: rtl/dff_pulse_timer.sv
// Down-counter that times the preset/clear pulse: loads PULSE_CYC-1, counts to zero, never wraps.
module dff_pulse_timer #(
  parameter int PULSE_CYC = 3
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic zero
);

  localparam int CW = $clog2(PULSE_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(PULSE_CYC - 1);

  logic [CW-1:0] count;

  // NOTE: non-blocking assignments for all registers so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dff_bank_seq_ctrl.sv
// Sequencer driving D/preset/clear of a DFF bank with readback check.
// Define DFF_READBACK_CHECK_EN to build the expected-value register and comparator.
module dff_bank_seq_ctrl
  import dff_bank_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PULSE_CYC = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             done,
  output logic             err,
  output logic             ff_pre,
  output logic             ff_clr,
  output logic [WIDTH-1:0] ff_d,
  input  logic [WIDTH-1:0] ff_q
);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic             accept;
  logic [1:0]       op_next;
  logic             timer_zero;
  logic             pre_d;
  logic             clr_d;

  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign done      = (state_q == ST_CHECK);
  assign op_next   = accept ? cmd_op : op_q;

  dff_pulse_timer #(
    .PULSE_CYC(PULSE_CYC)
  ) u_timer (
    .clk (clk),
    .clr (clr),
    .load(accept),
    .en  (state_q == ST_PULSE),
    .zero(timer_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ((cmd_op == OP_SET) || (cmd_op == OP_CLEAR)) ? ST_PULSE : ST_EXEC;
        end
      end
      ST_EXEC:  state_d = ST_CHECK;
      ST_PULSE: if (timer_zero) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pulse pins are decoded from the next state and registered, so they are glitch-free.
  assign pre_d = (state_d == ST_PULSE) && (op_next == OP_SET);
  assign clr_d = (state_d == ST_PULSE) && (op_next == OP_CLEAR);

  // Reset holds the bank cleared; ff_clr releases on the first edge after clr falls.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      ff_pre  <= 1'b0;
      ff_clr  <= 1'b1;
    end else begin
      state_q <= state_d;
      ff_pre  <= pre_d;
      ff_clr  <= clr_d;
      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
      end
    end
  end

  // NOTE: ff_d gets its default first so every path assigns it and no latch is inferred.
  always_comb begin
    ff_d = ff_q;
    if (state_q == ST_EXEC) begin
      if (op_q == OP_SHIFT) ff_d = {ff_q[WIDTH-2:0], data_q[0]};
      else                  ff_d = data_q;
    end
  end

`ifdef DFF_READBACK_CHECK_EN
  logic [WIDTH-1:0] exp_q;

  // The bank is held while a command is pending, so ff_q at accept is the SHIFT source.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      exp_q <= '0;
    end else if (accept) begin
      case (cmd_op)
        OP_LOAD:  exp_q <= cmd_data;
        OP_SET:   exp_q <= '1;
        OP_CLEAR: exp_q <= '0;
        default:  exp_q <= {ff_q[WIDTH-2:0], cmd_data[0]};
      endcase
    end
  end

  assign err = (state_q == ST_CHECK) && (ff_q != exp_q);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_bank_seq_ctrl.sv
// Self-checking bench: models a 4-bit async preset/clear DFF bank and scoreboards each command.
module tb_dff_bank_seq_ctrl;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

`ifdef DFF_READBACK_CHECK_EN
  localparam logic FORCE_ERR = 1'b1;
`else
  localparam logic FORCE_ERR = 1'b0;
`endif

  typedef struct {
    logic [3:0] q;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       done;
  logic       err;
  logic       ff_pre;
  logic       ff_clr;
  logic [3:0] ff_d;
  logic [3:0] ff_q;
  logic [3:0] bank_q;
  logic       force_zero;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ndone  = 0;
  int   npush  = 0;
  exp_t sb[$];
  exp_t mon_e;

  dff_bank_seq_ctrl #(.WIDTH(4), .PULSE_CYC(3)) dut (
    .clk      (clk),
    .clr      (clr),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .done     (done),
    .err      (err),
    .ff_pre   (ff_pre),
    .ff_clr   (ff_clr),
    .ff_d     (ff_d),
    .ff_q     (ff_q)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: clear dominates preset, both asynchronous.
  always @(posedge clk or posedge ff_pre or posedge ff_clr) begin
    if (ff_clr)      bank_q <= 4'b0000;
    else if (ff_pre) bank_q <= 4'b1111;
    else             bank_q <= ff_d;
  end

  assign ff_q = force_zero ? 4'b0000 : bank_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("done_q", ff_q, mon_e.q);
        check("done_err", err, mon_e.err);
        check("done_latency", cyc - mon_e.acc + 1, mon_e.lat);
        ndone++;
      end
    end else begin
      check("err_outside_check", err, 0);
    end
    check("pre_clr_exclusive", ff_pre & ff_clr, 0);
  end

  task automatic push_exp(input logic [3:0] q, input logic e, input int lat);
    exp_t x;
    x.q   = q;
    x.err = e;
    x.lat = lat;
    x.acc = cyc + 1;
    sb.push_back(x);
    npush++;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [3:0] eq,
                         input logic eerr, input int elat,
                         output int pre_cyc, output int clr_cyc, output logic [3:0] d_first);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    n = 0;
    while (!cmd_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!cmd_ready) check("accept_timeout", 0, 1);
    push_exp(eq, eerr, elat);
    @(negedge clk);
    cmd_valid = 1'b0;
    d_first = ff_d;
    pre_cyc = int'(ff_pre);
    clr_cyc = int'(ff_clr);
    n = 0;
    while (!done && n < 20) begin
      n++;
      @(negedge clk);
      pre_cyc += int'(ff_pre);
      clr_cyc += int'(ff_clr);
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  initial begin
    int         pre_n;
    int         clr_n;
    int         busy;
    int         dn;
    logic [3:0] d0;

    cmd_valid  = 1'b0;
    cmd_op     = OP_LOAD;
    cmd_data   = 4'b0000;
    force_zero = 1'b0;
    clr        = 1'b0;
    #5 clr = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_ff_clr", ff_clr, 1);
    check("rst_ff_pre", ff_pre, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_bank_q", ff_q, 4'b0000);
    @(negedge clk);
    clr = 1'b0;
    #1 check("ff_clr_held_after_release", ff_clr, 1);
    @(posedge clk);
    #1 check("ff_clr_falls_first_edge", ff_clr, 0);

    run_cmd(OP_LOAD, 4'b1010, 4'b1010, 1'b0, 2, pre_n, clr_n, d0);
    check("load_ff_d", d0, 4'b1010);
    check("load_no_pre", pre_n, 0);
    repeat (2) @(negedge clk);
    check("load_hold_q", ff_q, 4'b1010);

    run_cmd(OP_SET, 4'b0000, 4'b1111, 1'b0, 4, pre_n, clr_n, d0);
    check("set_pre_cycles", pre_n, 3);
    check("set_clr_cycles", clr_n, 0);

    run_cmd(OP_SHIFT, 4'b0000, 4'b1110, 1'b0, 2, pre_n, clr_n, d0);
    check("shift_ff_d", d0, 4'b1110);

    run_cmd(OP_CLEAR, 4'b1111, 4'b0000, 1'b0, 4, pre_n, clr_n, d0);
    check("clear_clr_cycles", clr_n, 3);
    check("clear_pre_cycles", pre_n, 0);

    force_zero = 1'b1;
    run_cmd(OP_LOAD, 4'b0101, 4'b0000, FORCE_ERR, 2, pre_n, clr_n, d0);
    #1 force_zero = 1'b0;
    @(negedge clk);
    check("bank_after_force", ff_q, 4'b0101);

    // SET interrupted by clr in its second pulse cycle; no done may follow.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort_pre_cycle1", ff_pre, 1);
    @(negedge clk);
    check("abort_pre_cycle2", ff_pre, 1);
    clr = 1'b1;
    #1;
    check("abort_pre_drops", ff_pre, 0);
    check("abort_ff_clr", ff_clr, 1);
    check("abort_ready", cmd_ready, 1);
    check("abort_bank_q", ff_q, 4'b0000);
    @(negedge clk);
    clr = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      dn += int'(done);
    end
    check("abort_no_done", dn, 0);

    // SET accepted, then a LOAD held valid while busy.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;
    cmd_data  = 4'b0000;
    push_exp(4'b1111, 1'b0, 4);
    @(negedge clk);
    cmd_op   = OP_LOAD;
    cmd_data = 4'b0011;
    busy = 0;
    while (!cmd_ready && busy < 20) begin
      check("busy_ready_low", cmd_ready, 0);
      busy++;
      @(negedge clk);
    end
    check("busy_cycles", busy, 4);
    push_exp(4'b0011, 1'b0, 2);
    @(negedge clk);
    cmd_valid = 1'b0;
    busy = 0;
    while (!done && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    check("held_load_done_seen", done, 1);
    repeat (6) @(negedge clk);
    check("held_bank_q", ff_q, 4'b0011);
    check("scoreboard_empty", sb.size(), 0);
    check("done_count", ndone, npush);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
